// File: rtl/audio_pkg.sv
// Shared constants and helpers for the PDM audio path.
// CIC sizing and PCM scaling are derived from the filter parameters.
package audio_pkg;

  // Integrator width: N*L bits of growth plus one so 2^(N*L) fits.
  function automatic int cic_width(input int order, input int dlog2);
    return order * dlog2 + 1;
  endfunction

  function automatic int cic_shift(input int order, input int dlog2,
                                   input int ow);
    return order * dlog2 - ow;
  endfunction

  // Maps the 0/1 stream's unsigned CIC output onto a zero-centred range.
  function automatic int cic_offset(input int order, input int dlog2);
    return 1 << (order * dlog2 - 1);
  endfunction

  function automatic int pcm_max(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction

  function automatic int pcm_min(input int ow);
    return -(1 << (ow - 1));
  endfunction

endpackage

// File: rtl/audio_rate_divider.sv
// Fractional bit-rate tick generator (clk * mul / div).
// Shared by transmit and receive so both ends agree on the bit rate.
module audio_rate_divider #(
  parameter int FACTOR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FACTOR_WIDTH-1:0] factor_mul,
  input  logic [FACTOR_WIDTH-1:0] factor_div,
  output logic                    tick
);

  logic [FACTOR_WIDTH-1:0] acc;
  logic [FACTOR_WIDTH:0]   sum;
  logic [FACTOR_WIDTH-1:0] rem;
  logic                    active;
  logic                    hit;

  always_comb begin
    sum    = {1'b0, acc} + {1'b0, factor_mul};
    rem    = FACTOR_WIDTH'(sum - {1'b0, factor_div});
    active = (factor_mul != '0) && (factor_div != '0);
    hit    = active && (sum >= {1'b0, factor_div});
  end

  assign tick = hit && !reset;

  // Above unity rate the residue is dropped so one tick per cycle holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (hit) begin
      acc <= (factor_mul > factor_div) ? '0 : rem;
    end else if (active) begin
      acc <= sum[FACTOR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pdm_audio_receiver.sv
// PDM receiver: resync, fractional-rate sampling, CIC decimation.
// Produces signed PCM with a one-cycle valid strobe.
module pdm_audio_receiver
  import audio_pkg::*;
#(
  parameter int CIC_ORDER    = 3,
  parameter int DECIM_LOG2   = 6,
  parameter int OUT_WIDTH    = 16,
  parameter int FACTOR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [FACTOR_WIDTH-1:0] factor_mul,
  input  logic [FACTOR_WIDTH-1:0] factor_div,
  input  logic                    pdm_in,
  output logic                    bit_tick,
  output logic [OUT_WIDTH-1:0]    sample_out,
  output logic                    sample_valid
);

  localparam int W     = cic_width(CIC_ORDER, DECIM_LOG2);
  localparam int SHIFT = cic_shift(CIC_ORDER, DECIM_LOG2, OUT_WIDTH);

  localparam logic [W-1:0] OFFSET =
    W'(cic_offset(CIC_ORDER, DECIM_LOG2));
  localparam logic signed [W-1:0] SAT_HI = W'(pcm_max(OUT_WIDTH));
  localparam logic signed [W-1:0] SAT_LO = W'(pcm_min(OUT_WIDTH));

  logic [1:0]            sync;
  logic                  tick;
  logic [DECIM_LOG2-1:0] dec_cnt;
  logic                  dec_strobe;
  logic [W-1:0]          integ   [CIC_ORDER];
  logic [W-1:0]          dly     [CIC_ORDER];
  logic [W-1:0]          comb_in [CIC_ORDER];
  logic [W-1:0]          cic;
  logic signed [W-1:0]   centered;
  logic signed [W-1:0]   scaled;
  logic [OUT_WIDTH-1:0]  pcm;

  audio_rate_divider #(
    .FACTOR_WIDTH(FACTOR_WIDTH)
  ) u_rate (
    .clk       (clk),
    .reset     (reset),
    .factor_mul(factor_mul),
    .factor_div(factor_div),
    .tick      (tick)
  );

  assign bit_tick = tick;

  // Comb chain runs on a running variable to avoid a self-looped array.
  always_comb begin
    logic [W-1:0] c;
    c = integ[CIC_ORDER-1];
    for (int k = 0; k < CIC_ORDER; k++) begin
      comb_in[k] = c;
      c          = c - dly[k];
    end
    cic = c;
  end

  always_comb begin
    centered = $signed(cic - OFFSET);
    scaled   = centered >>> SHIFT;
    unique case (1'b1)
      scaled > SAT_HI: pcm = OUT_WIDTH'(SAT_HI);
      scaled < SAT_LO: pcm = OUT_WIDTH'(SAT_LO);
      default:         pcm = OUT_WIDTH'(scaled);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync         <= '0;
      dec_cnt      <= '0;
      dec_strobe   <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
    end else begin
      sync         <= {sync[0], pdm_in};
      dec_strobe   <= tick && (dec_cnt == '1);
      sample_valid <= dec_strobe;
      if (tick) begin
        dec_cnt  <= dec_cnt + DECIM_LOG2'(1);
        integ[0] <= integ[0] + W'(sync[1]);
        for (int k = 1; k < CIC_ORDER; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
      end
      if (dec_strobe) begin
        sample_out <= pcm;
        for (int k = 0; k < CIC_ORDER; k++) begin
          dly[k] <= comb_in[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_audio_receiver.sv
// Randomised bench for pdm_audio_receiver against a convolution model.
// The model treats the CIC as its impulse response (sum z^-d)^N.
module tb_pdm_audio_receiver;

  localparam int N    = 3;
  localparam int L    = 6;
  localparam int R    = 1 << L;
  localparam int OW   = 16;
  localparam int FW   = 32;
  localparam int HLEN = N * (R - 1) + 1;
  localparam int SH   = N * L - OW;
  localparam longint OFF  = longint'(1) << (N * L - 1);
  localparam longint PMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint PMIN = -(longint'(1) << (OW - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] factor_mul = '0;
  logic [FW-1:0] factor_div = '0;
  logic          pdm_in = 1'b0;
  logic          bit_tick;
  logic [OW-1:0] sample_out;
  logic          sample_valid;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint h [HLEN];

  pdm_audio_receiver #(
    .CIC_ORDER   (N),
    .DECIM_LOG2  (L),
    .OUT_WIDTH   (OW),
    .FACTOR_WIDTH(FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .factor_mul  (factor_mul),
    .factor_div  (factor_div),
    .pdm_in      (pdm_in),
    .bit_tick    (bit_tick),
    .sample_out  (sample_out),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Output after m*R ticks: y[n] = sum h[j] x[n-N-j], then scaled.
  function automatic longint pcm_of(input int bits[$]);
    longint cic;
    longint v;
    int     n;
    int     idx;
    cic = 0;
    n   = bits.size();
    for (int j = 0; j < HLEN; j++) begin
      idx = n - N - j;
      if (idx >= 0) cic += h[j] * bits[idx];
    end
    v = (cic - OFF) >>> SH;
    if (v > PMAX) v = PMAX;
    if (v < PMIN) v = PMIN;
    return v;
  endfunction

  // mode: 0 const0, 1 const1, 2 toggle per cycle,
  //       3 random with arg% ones, 4 zero until cycle arg then one.
  task automatic run_case(input int mul, input int div, input int mode,
                          input int arg, input int ncyc,
                          output int ticks, output int adj,
                          output int nvalid, output int first_v,
                          output longint last_out);
    int     bits[$];
    bit     hist[$];
    int     due;
    longint pend;
    longint exp_out;
    bit     prev;
    bit     chk_each;
    ticks    = 0;
    adj      = 0;
    nvalid   = 0;
    first_v  = -1;
    due      = -1;
    pend     = 0;
    exp_out  = 0;
    prev     = 1'b0;
    chk_each = (ncyc <= 5000);
    factor_mul = FW'(mul);
    factor_div = FW'(div);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bit     d;
      bit     exp_tick;
      longint cm;
      case (mode)
        0:       d = 1'b0;
        1:       d = 1'b1;
        2:       d = c[0];
        3:       d = ($urandom_range(0, 99) < arg);
        default: d = (c >= arg);
      endcase
      pdm_in = d;
      hist.push_back(d);
      cm = longint'(c) * mul;
      exp_tick = (mul != 0) && (div != 0) &&
                 ((cm + mul) / div != cm / div);
      @(negedge clk);
      if (chk_each) check("tick", bit_tick, exp_tick);
      if (bit_tick) ticks++;
      if (bit_tick && prev) adj++;
      prev = bit_tick;
      check("valid", sample_valid, (c == due));
      if (sample_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
      end
      if (c == due) begin
        exp_out = pend;
        check("pcm", $signed(sample_out), exp_out);
      end else if (chk_each) begin
        check("hold", $signed(sample_out), exp_out);
      end
      if (exp_tick) begin
        bits.push_back((c >= 2) ? int'(hist[c-2]) : 0);
        if (bits.size() % R == 0) begin
          pend = pcm_of(bits);
          due  = c + 2;
        end
      end
      last_out = $signed(sample_out);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    longint t [HLEN];
    int     tk, aj, nv, fv;
    longint lo;
    int     mul, div, p;

    for (int k = 0; k < HLEN; k++) h[k] = (k == 0) ? 1 : 0;
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < HLEN; k++) begin
        t[k] = 0;
        for (int d = 0; d < R; d++)
          if (k - d >= 0) t[k] += h[k-d];
      end
      for (int k = 0; k < HLEN; k++) h[k] = t[k];
    end

    run_case(3, 1000, 3, 50, 20000, tk, aj, nv, fv, lo);
    check("rate_cnt", tk, 60);
    check("rate_adj", aj, 0);

    run_case(3, 0, 3, 50, 1000, tk, aj, nv, fv, lo);
    check("div0_cnt", tk, 0);

    run_case(1, 4, 1, 0, 4 * 256 + 4, tk, aj, nv, fv, lo);
    check("fs_sat", lo, 32767);
    check("fs_nvalid", nv, 4);

    run_case(1, 4, 0, 0, 800, tk, aj, nv, fv, lo);
    check("neg_sat", lo, -32768);

    run_case(1, 1, 2, 0, 400, tk, aj, nv, fv, lo);
    check("mid_zero", lo, 0);

    run_case(1, 1, 4, 190, 390, tk, aj, nv, fv, lo);
    check("lat_first", fv, 65);
    check("lat_sat", lo, 32767);

    run_case(1, 4, 1, 0, 890, tk, aj, nv, fv, lo);
    check("pre_rst_sat", lo, 32767);
    run_case(1, 4, 1, 0, 300, tk, aj, nv, fv, lo);
    check("rst_nvalid", nv, 1);
    check("rst_first", fv, 257);

    for (int i = 0; i < 3; i++) begin
      div = $urandom_range(1, 6);
      mul = $urandom_range(1, div);
      p   = $urandom_range(0, 100);
      run_case(mul, div, 3, p, 5 * R * div / mul + 10,
               tk, aj, nv, fv, lo);
      check("rnd_nvalid", nv, 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
